// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Purpose  : Round-robin sharing of one external 32-bit add/sub datapath among
//            NREQ requesters, with a single-entry result register.
//            Optional: ADDER_ARB_SIGNED_OVF_EN builds signed-overflow capture.
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_ovf
);

    localparam logic [NREQ-1:0] c_ONE     = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]  c_LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0] r_ptr_q,       w_ptr_d;
    logic           r_rsp_valid_q, w_rsp_valid_d;
    logic [IDW-1:0] r_rsp_id_q,    w_rsp_id_d;
    logic [31:0]    r_rsp_sum_q,   w_rsp_sum_d;
    logic           r_rsp_carry_q, w_rsp_carry_d;
    logic           r_rsp_zero_q,  w_rsp_zero_d;

    logic           w_can_accept;
    logic           w_any_valid;
    logic           w_hi_found;
    logic [IDW-1:0] w_gnt_lo;
    logic [IDW-1:0] w_gnt_hi;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_grant;

    assign w_can_accept = !r_rsp_valid_q || rsp_ready;
    assign w_any_valid  = |req_valid;

    // Descending scan leaves the lowest matching index in each candidate:
    // w_gnt_hi is the lowest valid at or above the pointer, w_gnt_lo the wrap.
    always_comb begin
        w_gnt_lo   = '0;
        w_gnt_hi   = '0;
        w_hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_gnt_lo = IDW'(i);
            end
            if (req_valid[i] && (IDW'(i) >= r_ptr_q)) begin
                w_gnt_hi   = IDW'(i);
                w_hi_found = 1'b1;
            end
        end
        w_gnt_idx = w_hi_found ? w_gnt_hi : w_gnt_lo;
    end

    // Suppressing the grant during rst keeps the reset cycle from accepting.
    assign w_grant   = w_can_accept && w_any_valid && !rst;
    assign req_ready = w_grant ? (c_ONE << w_gnt_idx) : '0;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && (w_gnt_idx == IDW'(i))) begin
                add_a   = req_a[32*i +: 32];
                add_b   = req_b[32*i +: 32] ^ {32{req_sub[i]}};
                add_cin = req_sub[i];
            end
        end
    end

    always_comb begin
        w_ptr_d       = r_ptr_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_id_d    = r_rsp_id_q;
        w_rsp_sum_d   = r_rsp_sum_q;
        w_rsp_carry_d = r_rsp_carry_q;
        w_rsp_zero_d  = r_rsp_zero_q;
        if (w_grant) begin
            w_rsp_valid_d = 1'b1;
            w_rsp_id_d    = w_gnt_idx;
            w_rsp_sum_d   = add_sum;
            w_rsp_carry_d = add_cout;
            w_rsp_zero_d  = (add_sum == 32'd0);
            w_ptr_d       = (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + 1'b1;
        end else if (r_rsp_valid_q && rsp_ready) begin
            w_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q       <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_id_q    <= '0;
            r_rsp_sum_q   <= '0;
            r_rsp_carry_q <= 1'b0;
            r_rsp_zero_q  <= 1'b0;
        end else begin
            r_ptr_q       <= w_ptr_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_id_q    <= w_rsp_id_d;
            r_rsp_sum_q   <= w_rsp_sum_d;
            r_rsp_carry_q <= w_rsp_carry_d;
            r_rsp_zero_q  <= w_rsp_zero_d;
        end
    end

`ifdef ADDER_ARB_SIGNED_OVF_EN
    logic r_rsp_ovf_q, w_rsp_ovf_d;

    always_comb begin
        w_rsp_ovf_d = r_rsp_ovf_q;
        if (w_grant) begin
            w_rsp_ovf_d = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_ovf_q <= 1'b0;
        end else begin
            r_rsp_ovf_q <= w_rsp_ovf_d;
        end
    end

    assign rsp_ovf = r_rsp_ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid_q;
    assign rsp_id    = r_rsp_id_q;
    assign rsp_sum   = r_rsp_sum_q;
    assign rsp_carry = r_rsp_carry_q;
    assign rsp_zero  = r_rsp_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arb
// Purpose  : Directed scoreboard bench for adder_share_arb (NREQ=4), with a
//            behavioural model of the shared adder on the add_* lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        logic           carry;
        logic           zero;
        logic           ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic [31:0]          add_a;
    logic [31:0]          add_b;
    logic                 add_cin;
    logic [31:0]          add_sum;
    logic                 add_cout;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_carry;
    logic                 rsp_zero;
    logic                 rsp_ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Shared adder instance stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf)
    );

    function automatic exp_t model(input logic [IDW-1:0] id, input logic [31:0] a,
                                   input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [31:0] b2;
        logic [32:0] s;
        b2      = sub ? ~b : b;
        s       = {1'b0, a} + {1'b0, b2} + {32'd0, sub};
        e.id    = id;
        e.sum   = s[31:0];
        e.carry = s[32];
        e.zero  = (s[31:0] == 32'd0);
`ifdef ADDER_ARB_SIGNED_OVF_EN
        e.ovf   = (a[31] == b2[31]) && (s[31] != a[31]);
`else
        e.ovf   = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int i);
        sb.push_back(model(IDW'(i), req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i]));
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        total++;
        assert (sb.size() > 0)
        else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_id"},    64'(rsp_id),    64'(e.id));
            chk({tag, "_sum"},   64'(rsp_sum),   64'(e.sum));
            chk({tag, "_carry"}, 64'(rsp_carry), 64'(e.carry));
            chk({tag, "_zero"},  64'(rsp_zero),  64'(e.zero));
            chk({tag, "_ovf"},   64'(rsp_ovf),   64'(e.ovf));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id",    64'(rsp_id),    64'd0);
        chk("rst_sum",   64'(rsp_sum),   64'd0);
        chk("rst_carry", 64'(rsp_carry), 64'd0);
        chk("rst_zero",  64'(rsp_zero),  64'd0);
        chk("rst_ovf",   64'(rsp_ovf),   64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_adda",  64'(add_a),     64'd0);

        // Single add on requester 0.
        req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_valid = 4'b0001;
        #1;
        chk("add_ready", 64'(req_ready), 64'b0001);
        chk("add_a",     64'(add_a),     64'd5);
        chk("add_b",     64'(add_b),     64'd7);
        chk("add_cin",   64'(add_cin),   64'd0);
        push_req(0);
        tick();
        req_valid = '0;
        check_rsp("add");

        // Subtract to zero on requester 2 (pointer now 1), then 0-1 after wrap.
        req_a[95:64] = 32'h1234_5678; req_b[95:64] = 32'h1234_5678; req_sub = 4'b0100;
        req_valid = 4'b0100;
        #1;
        chk("sub_ready", 64'(req_ready), 64'b0100);
        chk("sub_b",     64'(add_b),     64'(32'hEDCB_A987));
        chk("sub_cin",   64'(add_cin),   64'd1);
        push_req(2);
        tick();
        check_rsp("subz");
        req_a[95:64] = 32'd0; req_b[95:64] = 32'd1;
        #1;
        chk("wrap_ready", 64'(req_ready), 64'b0100);
        push_req(2);
        tick();
        req_valid = '0;
        check_rsp("subm1");
        tick();
        chk("drain_valid", 64'(rsp_valid), 64'd0);

        // Reset mid-stream: pending result discarded, pointer returns to 0.
        req_a[31:0] = 32'd9; req_b[31:0] = 32'd1; req_sub = '0; req_valid = 4'b0001;
        #1;
        push_req(0);
        tick();
        req_valid = '0;
        check_rsp("pre_rst");
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(rsp_valid), 64'd0);

        // Round robin with all requesters held valid; requester 1 overflows.
        req_a[31:0]   = 32'd100;         req_b[31:0]   = 32'd23;
        req_a[63:32]  = 32'h7FFF_FFFF;   req_b[63:32]  = 32'd1;
        req_a[95:64]  = 32'hFFFF_FFFF;   req_b[95:64]  = 32'd2;
        req_a[127:96] = 32'd10;          req_b[127:96] = 32'd20;
        req_sub = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
            push_req(k % 4);
            tick();
            check_rsp($sformatf("rr%0d", k));
        end

        // Backpressure: result held, nothing accepted.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
            tick();
            chk($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp%0d_id", k),    64'(rsp_id),    64'd0);
            chk($sformatf("bp%0d_sum", k),   64'(rsp_sum),   64'd123);
        end
        rsp_ready = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'b0010);
        push_req(1);
        tick();
        req_valid = '0;
        check_rsp("rel");
        tick();
        chk("end_valid", 64'(rsp_valid), 64'd0);
        chk("end_sb",    64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin scheduler that shares one combinational 32-bit add/sub datapath among NREQ requesters (ALU, address generator, branch-target unit, etc.). It arbitrates valid/ready requests and drives the shared adder's operand and carry-in lines. Each completed result, with carry, zero and requester ID, is captured in a single-entry output register with a valid/ready drain handshake. It sits between the execute-stage requesters and the shared adder instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  32*NREQ  operand A, requester i at [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- req_sub  in  NREQ  1 = A-B, 0 = A+B
- add_a  out  32  to shared adder operand A
- add_b  out  32  to shared adder operand B (already inverted for subtract)
- add_cin  out  1  to shared adder carry-in
- add_sum  in  32  from shared adder sum
- add_cout  in  1  from shared adder carry-out
- rsp_valid  out  1  result register holds valid data
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester index of result
- rsp_sum  out  32  result
- rsp_carry  out  1  adder carry-out (for subtract: 1 = no borrow)
- rsp_zero  out  1  rsp_sum == 0
- rsp_ovf  out  1  signed overflow (see Configuration)

## Operation
- Clock is clk; reset is rst, synchronous and active-high.
- can_accept = !rsp_valid || rsp_ready (register empty or draining this cycle).
- Arbitration: combinational round-robin over req_valid starting at pointer ptr. Lowest index ≥ ptr wins, wrapping to 0.
- When can_accept and any req_valid: assert req_ready[g] for the winner g only; accept = req_valid[g] && req_ready[g].
- add_a = req_a[g], add_b = req_b[g] ^ {32{req_sub[g]}}, add_cin = req_sub[g]. With no grant, drive add_a/add_b/add_cin to 0.
- On accept: rsp_sum<=add_sum, rsp_carry<=add_cout, rsp_zero<=(add_sum==0), rsp_id<=g, rsp_valid<=1, ptr<=(g+1) mod NREQ.
- No accept and rsp_ready && rsp_valid: rsp_valid<=0; data fields hold.
- No accept and no drain: all state holds; ptr changes only on accept.
- Stall: !can_accept drives req_ready all-zero. Requesters must hold req_a/req_b/req_sub stable while req_valid is high and unaccepted.
- Requester with req_valid=0 never receives req_ready.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_zero=0, rsp_ovf=0, ptr=0. req_ready and add_* follow combinationally (all 0 while rsp_valid=0 and no req_valid).
- Latency: accept on edge k gives rsp_valid=1 with result after edge k (1 cycle).
- Throughput: 1 result/cycle while rsp_ready=1; simultaneous drain and accept in the same cycle is required (no bubble).
- rsp_ready=0 with rsp_valid=1: result holds, no new accept.
- Fairness: with all NREQ requesting continuously and rsp_ready=1, grants rotate 0,1,..,NREQ-1,0.
- Reset mid-operation: pending result is discarded, ptr returns to 0, req_ready=0 during the rst cycle.
- Arithmetic is modulo 2^32; carry wraps out via rsp_carry only.

## Configuration
- ADDER_ARB_SIGNED_OVF_EN defined: rsp_ovf is registered on accept as (add_a[31]==add_b[31]) && (add_sum[31]!=add_a[31]).
- Not defined: rsp_ovf is constant 0 and no overflow logic is built. All other behaviour is identical.

## Test plan
- Reset then single add: req0 A=5, B=7, sub=0 -> next cycle rsp_valid=1, id=0, sum=12, carry=0, zero=0.
- Subtract to zero: req2 A=B=0x1234_5678, sub=1 -> sum=0, zero=1, carry=1. Also A=0, B=1, sub=1 -> sum=0xFFFF_FFFF, carry=0.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> ids 0,1,2,3,0 on consecutive cycles, one-hot req_ready each cycle.
- Backpressure: rsp_ready=0 for 3 cycles with result held -> req_ready=0, rsp fields stable. Release -> drain and next accept on the same edge.
- Overflow (macro on): A=0x7FFF_FFFF, B=1, sub=0 -> sum=0x8000_0000, ovf=1. With macro off, ovf=0.
- Reset mid-stream: rst asserted with rsp_valid=1 -> next cycle rsp_valid=0, and the next grant goes to requester 0.
